// File: rtl/fpu_op_issue_pkg.sv
// ============================================================================
// Module : fpu_op_issue_pkg
// Brief  : Shared FPU definitions: legal opcode ranges, occupancy encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fpu_op_issue_pkg;

    localparam int IDLE_PD_CYC_DEF = 16;

    localparam logic [7:0] OP_R0_LO = 8'h62;
    localparam logic [7:0] OP_R0_HI = 8'h73;
    localparam logic [7:0] OP_R1_LO = 8'h76;
    localparam logic [7:0] OP_R1_HI = 8'h77;
    localparam logic [7:0] OP_R2_LO = 8'h86;
    localparam logic [7:0] OP_R2_HI = 8'h8F;
    localparam logic [7:0] OP_R3_LO = 8'h95;
    localparam logic [7:0] OP_R3_HI = 8'h98;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/fpu_op_issue_legal.sv
// ============================================================================
// Module : fpu_op_legal
// Brief  : Combinational check that an 8-bit opcode belongs to the FP set.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fpu_op_legal
    import fpu_op_issue_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic       legal_o
);

    assign legal_o = ((opcode_i >= OP_R0_LO) && (opcode_i <= OP_R0_HI)) ||
                     ((opcode_i >= OP_R1_LO) && (opcode_i <= OP_R1_HI)) ||
                     ((opcode_i >= OP_R2_LO) && (opcode_i <= OP_R2_HI)) ||
                     ((opcode_i >= OP_R3_LO) && (opcode_i <= OP_R3_HI));

endmodule

`default_nettype wire

// File: rtl/fpu_op_issue.sv
// ============================================================================
// Module : fpu_op_issue
// Brief  : Two-entry FP opcode queue between the IU and the microcode
//          sequencer, with illegal-opcode pulse and idle powerdown request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fpu_op_issue
    import fpu_op_issue_pkg::*;
#(
    parameter int IDLE_PD_CYC = IDLE_PD_CYC_DEF,
    parameter int DEPTH       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iu_fpop,
    input  logic       iu_fpop_valid,
    input  logic       fpkill,
    input  logic       fpuhold,
    input  logic       fpbusyn,
    output logic [7:0] nx_opcode,
    output logic       nx_fpop_valid,
    output logic       fpop_stall,
    output logic       fp_illegal,
    output logic       powerdown
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(IDLE_PD_CYC + 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_PD_CYC);

    occ_state_e    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    head_q, head_d;
    logic          valid_q;
    logic          illegal_q;
    logic [CW-1:0] idle_q, idle_d;
    logic          op_legal;
    logic          accept;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    fpu_op_legal u_legal (
        .opcode_i (iu_fpop),
        .legal_o  (op_legal)
    );

    assign accept     = iu_fpop_valid & ~fpop_stall & ~fpkill;
    assign push       = accept & op_legal;
    assign pop        = valid_q & fpbusyn & ~fpuhold & ~fpkill;
    assign fpop_stall = (state_q == TWO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fpkill) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = TWO;
                    else if (pop && !push) state_d = EMPTY;
                end
                TWO:     if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fpkill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // The new head is the entry being written this cycle when the slot it
        // lands in is exactly where the read pointer will point next.
        head_d = head_q;
        if (state_d != EMPTY)
            head_d = (push && (wr_ptr_q == rd_ptr_d)) ? iu_fpop : mem_q[rd_ptr_d];

        idle_d = idle_q;
        if (push || !fpbusyn || fpkill)
            idle_d = '0;
        else if ((state_q == EMPTY) && (idle_q != IDLE_MAX))
            idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= iu_fpop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            head_q    <= head_d;
            valid_q   <= (state_d != EMPTY);
            illegal_q <= accept & ~op_legal;
            idle_q    <= idle_d;
        end
    end

    assign nx_opcode     = head_q;
    assign nx_fpop_valid = valid_q;
    assign fp_illegal    = illegal_q;
    assign powerdown     = (idle_q == IDLE_MAX);

endmodule

`default_nettype wire

// File: tb/tb_fpu_op_issue.sv
// ============================================================================
// Module : tb_fpu_op_issue
// Brief  : Directed self-checking bench for the FP opcode issue queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_op_issue;

    logic       clk;
    logic       reset;
    logic [7:0] iu_fpop;
    logic       iu_fpop_valid;
    logic       fpkill;
    logic       fpuhold;
    logic       fpbusyn;
    logic [7:0] nx_opcode;
    logic       nx_fpop_valid;
    logic       fpop_stall;
    logic       fp_illegal;
    logic       powerdown;

    int checks;
    int errors;

    fpu_op_issue #(.IDLE_PD_CYC(16), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .iu_fpop       (iu_fpop),
        .iu_fpop_valid (iu_fpop_valid),
        .fpkill        (fpkill),
        .fpuhold       (fpuhold),
        .fpbusyn       (fpbusyn),
        .nx_opcode     (nx_opcode),
        .nx_fpop_valid (nx_fpop_valid),
        .fpop_stall    (fpop_stall),
        .fp_illegal    (fp_illegal),
        .powerdown     (powerdown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({nx_opcode, nx_fpop_valid, fpop_stall, fp_illegal, powerdown} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got op=%h v=%b st=%b ill=%b pd=%b, want all zero",
                     nx_opcode, nx_fpop_valid, fpop_stall, fp_illegal, powerdown);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_issue();
        fpbusyn = 1'b1;
        iu_fpop = 8'h62; iu_fpop_valid = 1'b1;
        tick();
        iu_fpop_valid = 1'b0;
        checks++;
        if (nx_fpop_valid !== 1'b1 || nx_opcode !== 8'h62) begin
            errors++;
            $display("FAIL single_present: got v=%b op=%h, want v=1 op=62", nx_fpop_valid, nx_opcode);
        end
        tick();
        checks++;
        if (nx_fpop_valid !== 1'b0 || nx_opcode !== 8'h62 || fpop_stall !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: got v=%b op=%h st=%b, want v=0 op=62 st=0",
                     nx_fpop_valid, nx_opcode, fpop_stall);
        end
    endtask

    task automatic test_back_to_back();
        fpbusyn = 1'b0;
        iu_fpop = 8'h6A; iu_fpop_valid = 1'b1;
        tick();
        checks++;
        if (nx_opcode !== 8'h6A || nx_fpop_valid !== 1'b1 || fpop_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got op=%h v=%b st=%b, want 6A 1 0", nx_opcode, nx_fpop_valid, fpop_stall);
        end
        iu_fpop = 8'h63;
        tick();
        checks++;
        if (fpop_stall !== 1'b1 || nx_opcode !== 8'h6A) begin
            errors++;
            $display("FAIL b2b_full: got st=%b op=%h, want st=1 op=6A", fpop_stall, nx_opcode);
        end
        // 0x70 is held while full; it must only enter once a slot frees.
        iu_fpop = 8'h70;
        tick();
        checks++;
        if (fpop_stall !== 1'b1 || nx_opcode !== 8'h6A) begin
            errors++;
            $display("FAIL b2b_stalled: got st=%b op=%h, want st=1 op=6A", fpop_stall, nx_opcode);
        end
        fpbusyn = 1'b1;
        tick();
        checks++;
        if (nx_opcode !== 8'h63 || nx_fpop_valid !== 1'b1 || fpop_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pop1: got op=%h v=%b st=%b, want 63 1 0", nx_opcode, nx_fpop_valid, fpop_stall);
        end
        tick();
        iu_fpop_valid = 1'b0;
        checks++;
        if (nx_opcode !== 8'h70 || nx_fpop_valid !== 1'b1 || fpop_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pushpop: got op=%h v=%b st=%b, want 70 1 0", nx_opcode, nx_fpop_valid, fpop_stall);
        end
        tick();
        checks++;
        if (nx_fpop_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b, want 0", nx_fpop_valid);
        end
    endtask

    task automatic test_hold();
        fpbusyn = 1'b1; fpuhold = 1'b1;
        iu_fpop = 8'h64; iu_fpop_valid = 1'b1;
        tick();
        iu_fpop = 8'h65;
        tick();
        iu_fpop_valid = 1'b0;
        tick();
        checks++;
        if (nx_opcode !== 8'h64 || fpop_stall !== 1'b1) begin
            errors++;
            $display("FAIL hold_frozen: got op=%h st=%b, want 64 1", nx_opcode, fpop_stall);
        end
        fpuhold = 1'b0;
        tick();
        checks++;
        if (nx_opcode !== 8'h65 || fpop_stall !== 1'b0 || nx_fpop_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got op=%h st=%b v=%b, want 65 0 1", nx_opcode, fpop_stall, nx_fpop_valid);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [7:0] ops [16];
        logic       lgl [16];
        ops = '{8'h61, 8'h62, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78,
                8'h85, 8'h86, 8'h8F, 8'h90, 8'h94, 8'h95, 8'h98, 8'h99};
        lgl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        fpbusyn = 1'b1;
        iu_fpop = 8'h60; iu_fpop_valid = 1'b1;
        tick();
        iu_fpop_valid = 1'b0;
        checks++;
        if (fp_illegal !== 1'b1 || nx_fpop_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_60: got ill=%b v=%b, want 1 0", fp_illegal, nx_fpop_valid);
        end
        tick();
        checks++;
        if (fp_illegal !== 1'b0 || nx_fpop_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_end: got ill=%b v=%b, want 0 0", fp_illegal, nx_fpop_valid);
        end
        for (int i = 0; i < 16; i++) begin
            iu_fpop = ops[i]; iu_fpop_valid = 1'b1;
            tick();
            iu_fpop_valid = 1'b0;
            checks++;
            if (fp_illegal !== !lgl[i] || nx_fpop_valid !== lgl[i]
                || (lgl[i] && nx_opcode !== ops[i])) begin
                errors++;
                $display("FAIL legal_range op=%h: got ill=%b v=%b nx=%h, want ill=%b v=%b",
                         ops[i], fp_illegal, nx_fpop_valid, nx_opcode, !lgl[i], lgl[i]);
            end
            tick();
        end
    endtask

    task automatic test_kill();
        fpbusyn = 1'b0;
        iu_fpop = 8'h86; iu_fpop_valid = 1'b1;
        tick();
        iu_fpop = 8'h87;
        tick();
        checks++;
        if (fpop_stall !== 1'b1) begin
            errors++;
            $display("FAIL kill_setup: got st=%b, want 1", fpop_stall);
        end
        fpkill = 1'b1; iu_fpop = 8'h95;
        tick();
        fpkill = 1'b0; iu_fpop_valid = 1'b0;
        checks++;
        if (nx_fpop_valid !== 1'b0 || fpop_stall !== 1'b0) begin
            errors++;
            $display("FAIL kill_flush: got v=%b st=%b, want 0 0", nx_fpop_valid, fpop_stall);
        end
        tick();
        checks++;
        if (nx_fpop_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_noqueue: got v=%b, want 0", nx_fpop_valid);
        end
        fpkill = 1'b1; iu_fpop = 8'h00; iu_fpop_valid = 1'b1;
        tick();
        checks++;
        if (fp_illegal !== 1'b0 || nx_fpop_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_suppress: got ill=%b v=%b, want 0 0", fp_illegal, nx_fpop_valid);
        end
        fpkill = 1'b0; iu_fpop_valid = 1'b0;
        tick();
    endtask

    task automatic test_powerdown();
        fpbusyn = 1'b0;
        tick();
        fpbusyn = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (powerdown !== 1'b0) begin
            errors++;
            $display("FAIL pd_early: got pd=%b after 15 idle, want 0", powerdown);
        end
        tick();
        checks++;
        if (powerdown !== 1'b1) begin
            errors++;
            $display("FAIL pd_assert: got pd=%b after 16 idle, want 1", powerdown);
        end
        tick();
        checks++;
        if (powerdown !== 1'b1) begin
            errors++;
            $display("FAIL pd_saturate: got pd=%b, want 1", powerdown);
        end
        iu_fpop = 8'h77; iu_fpop_valid = 1'b1;
        tick();
        iu_fpop_valid = 1'b0;
        checks++;
        if (powerdown !== 1'b0 || nx_opcode !== 8'h77 || nx_fpop_valid !== 1'b1) begin
            errors++;
            $display("FAIL pd_wake: got pd=%b op=%h v=%b, want 0 77 1", powerdown, nx_opcode, nx_fpop_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        fpbusyn = 1'b0; fpuhold = 1'b1;
        iu_fpop = 8'h62; iu_fpop_valid = 1'b1;
        tick();
        iu_fpop = 8'h63;
        tick();
        iu_fpop_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({nx_opcode, nx_fpop_valid, fpop_stall, fp_illegal, powerdown} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: got op=%h v=%b st=%b ill=%b pd=%b, want all zero",
                     nx_opcode, nx_fpop_valid, fpop_stall, fp_illegal, powerdown);
        end
        tick();
        reset = 1'b0; fpuhold = 1'b0; fpbusyn = 1'b1;
        tick();
        iu_fpop = 8'h86; iu_fpop_valid = 1'b1;
        tick();
        iu_fpop_valid = 1'b0;
        checks++;
        if (nx_opcode !== 8'h86 || nx_fpop_valid !== 1'b1 || fpop_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_resume: got op=%h v=%b st=%b, want 86 1 0", nx_opcode, nx_fpop_valid, fpop_stall);
        end
        tick();
        checks++;
        if (nx_fpop_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_resume_pop: got v=%b, want 0", nx_fpop_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        iu_fpop = 8'h00;
        iu_fpop_valid = 1'b0;
        fpkill = 1'b0;
        fpuhold = 1'b0;
        fpbusyn = 1'b0;
        #1;
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_hold();
        test_illegal();
        test_kill();
        test_powerdown();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_op_issue.md
FPU_OP_ISSUE -- requirements
Module: fpu_op_issue

Interface
REQ-001 SHALL have parameter IDLE_PD_CYC, default 16, meaning idle cycles before powerdown request.
REQ-002 SHALL have parameter DEPTH, default 2, meaning opcode queue entries (fixed at 2 for this revision).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 iu_fpop  input  8  FP opcode from the integer unit.
REQ-006 iu_fpop_valid  input  1  iu_fpop valid this cycle.
REQ-007 fpkill  input  1  flush all queued and presented opcodes.
REQ-008 fpuhold  input  1  sequencer frozen; no pop.
REQ-009 fpbusyn  input  1  sequencer idle and able to accept an opcode (high = ready).
REQ-010 nx_opcode  output  8  head opcode presented to the microcode sequencer.
REQ-011 nx_fpop_valid  output  1  nx_opcode valid.
REQ-012 fpop_stall  output  1  queue full; IU holds iu_fpop.
REQ-013 fp_illegal  output  1  one-cycle pulse: non-FP opcode dropped.
REQ-014 powerdown  output  1  FPU idle long enough to gate clocks.

Function
REQ-015 Legal FP opcodes SHALL be 0x62-0x73, 0x76-0x77, 0x86-0x8F, 0x95-0x98; all others illegal.
REQ-016 Push SHALL occur when iu_fpop_valid=1, fpop_stall=0, fpkill=0 and opcode legal.
REQ-017 Illegal opcode with iu_fpop_valid=1, fpop_stall=0, fpkill=0 SHALL not be pushed; fp_illegal SHALL pulse next cycle.
REQ-018 Pop SHALL occur when nx_fpop_valid=1, fpbusyn=1, fpuhold=0, fpkill=0.
REQ-019 Occupancy FSM SHALL have states EMPTY, ONE, TWO; EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop; push+pop in ONE stays ONE.
REQ-020 fpop_stall SHALL equal (state==TWO), registered-state derived, no combinational path from inputs.
REQ-021 Push into TWO SHALL be impossible (stall); simultaneous pop in TWO frees a slot only the following cycle.
REQ-022 nx_opcode/nx_fpop_valid SHALL be driven from the head register; push-to-present latency SHALL be 1 cycle (push at edge N visible after edge N).
REQ-023 Entries SHALL leave in push order; pointers wrap modulo DEPTH.
REQ-024 fpkill SHALL force state EMPTY, nx_fpop_valid=0 at next edge and suppress same-cycle push, pop and fp_illegal.
REQ-025 fpuhold=1 SHALL freeze pop; push still allowed if not full.
REQ-026 Idle counter SHALL increment when state==EMPTY and fpbusyn=1, saturate at IDLE_PD_CYC, and clear on any push, fpbusyn=0 or fpkill.
REQ-027 powerdown SHALL be 1 exactly while idle counter == IDLE_PD_CYC; an accepted push drops it the next cycle.
REQ-028 nx_opcode SHALL hold its last value when nx_fpop_valid=0 (no X propagation).

Reset
REQ-029 reset=1 SHALL immediately set state EMPTY, pointers 0, idle counter 0, nx_opcode=0x00, nx_fpop_valid=0, fpop_stall=0, fp_illegal=0, powerdown=0.
REQ-030 Reset mid-operation SHALL discard queued opcodes; first push after reset release behaves as from EMPTY.

Structure
REQ-031 Legal-opcode ranges, state encoding (EMPTY=2'b00, ONE=2'b01, TWO=2'b10) and IDLE_PD_CYC default SHALL live in the shared FPU package.
REQ-032 Opcode legality check SHALL be one sub-module, fpu_op_legal (combinational, 8-bit in, 1-bit out).

Verification
REQ-033 Push 0x62 on idle, fpbusyn=1 -> nx_fpop_valid=1, nx_opcode=0x62 next cycle, popped following cycle, state EMPTY.
REQ-034 fpbusyn=0, push 0x6A then 0x63 -> fpop_stall=1 after second push; release fpbusyn -> 0x6A then 0x63 issued in order, stall drops one cycle after first pop.
REQ-035 Push 0x60 (iadd) -> no enqueue, fp_illegal pulses one cycle, nx_fpop_valid stays 0.
REQ-036 State TWO, fpkill=1 with iu_fpop_valid=1 (0x95) -> next cycle EMPTY, nx_fpop_valid=0, 0x95 not queued.
REQ-037 EMPTY, fpbusyn=1 for 16 cycles -> powerdown=1 on 16th count; push 0x77 -> powerdown=0 next cycle.
REQ-038 Assert reset while TWO with fpuhold=1 -> all outputs reset values immediately; after release, push 0x86 issues normally.
